// File: rtl/halt_controller_if.sv
// Pipeline halt handshake: decode/hazard requests in, fetch enables and status out.
interface halt_controller_if;
  logic       halt;
  logic       id_valid;
  logic       stall_in;
  logic       resume;
  logic       pc_en;
  logic       ifid_en;
  logic       idex_flush;
  logic       draining;
  logic       halted;
  logic [7:0] halt_count;

  modport master (
    output halt, id_valid, stall_in, resume,
    input  pc_en, ifid_en, idex_flush, draining, halted, halt_count
  );

  modport slave (
    input  halt, id_valid, stall_in, resume,
    output pc_en, ifid_en, idex_flush, draining, halted, halt_count
  );
endinterface

// File: rtl/halt_controller.sv
// Halt controller: on FENCE/SYSTEM in ID, freezes fetch, drains EX/MEM/WB,
// parks in HALTED until resume.
module halt_controller #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  halt_controller_if.slave  bus
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t             state, nxt;
  logic [CNT_W-1:0]   cnt;
  logic [7:0]         halt_count;
  logic               take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      cnt        <= '0;
      halt_count <= '0;
    end else begin
      state <= nxt;
      if (take) begin
        cnt <= CNT_W'(DRAIN_CYCLES - 1);
        if (halt_count != 8'hff) halt_count <= halt_count + 8'd1;
      end else if (state == DRAIN && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    nxt            = state;
    take           = 1'b0;
    bus.pc_en      = ~bus.stall_in;
    bus.ifid_en    = ~bus.stall_in;
    bus.idex_flush = bus.stall_in;
    unique case (state)
      RUN: begin
        // Held in reset, the state reads RUN but no halt may be taken.
        take = bus.halt & bus.id_valid & ~bus.stall_in & ~rst;
        if (take) begin
          bus.pc_en      = 1'b0;
          bus.ifid_en    = 1'b0;
          bus.idex_flush = 1'b1;
          nxt            = DRAIN;
        end
      end
      DRAIN: begin
        bus.pc_en      = 1'b0;
        bus.ifid_en    = 1'b0;
        bus.idex_flush = 1'b1;
        if (cnt == '0) nxt = HALTED;
      end
      HALTED: begin
        // Resume fetches past the halting instruction; the one in ID is squashed.
        bus.pc_en      = bus.resume;
        bus.ifid_en    = bus.resume;
        bus.idex_flush = 1'b1;
        if (bus.resume) nxt = RUN;
      end
      default: nxt = RUN;
    endcase
  end

  assign bus.draining   = (state == DRAIN);
  assign bus.halted     = (state == HALTED);
  assign bus.halt_count = halt_count;

endmodule

// File: tb/tb_halt_controller.sv
// Self-checking bench for halt_controller: directed table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_halt_controller;
  localparam int DC = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  halt_controller_if bus();

  halt_controller #(.DRAIN_CYCLES(DC), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // model: drain cycles still to run, parked flag, saturating halt tally
  int m_drain;
  bit m_halted;
  int m_cnt;

  typedef struct {
    bit h, v, s, r;
    logic [12:0] exp; // {pc_en, ifid_en, idex_flush, draining, halted, halt_count}
  } vec_t;

  function automatic logic [12:0] obs();
    return {bus.pc_en, bus.ifid_en, bus.idex_flush, bus.draining, bus.halted, bus.halt_count};
  endfunction

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [12:0] model_exp(input bit h, v, s, r);
    logic [7:0] c;
    c = 8'(m_cnt);
    if (m_drain > 0) return {3'b001, 2'b10, c};
    if (m_halted)    return {r, r, 1'b1, 2'b01, c};
    if (h && v && !s) return {3'b001, 2'b00, c};
    return {!s, !s, s, 2'b00, c};
  endfunction

  task automatic model_upd(input bit h, v, s, r);
    if (m_drain > 0) begin
      m_drain--;
      if (m_drain == 0) m_halted = 1'b1;
    end else if (m_halted) begin
      if (r) m_halted = 1'b0;
    end else if (h && v && !s) begin
      m_drain = DC;
      m_cnt   = (m_cnt >= 255) ? 255 : m_cnt + 1;
    end
  endtask

  task automatic drive(input bit h, v, s, r);
    bus.halt = h; bus.id_valid = v; bus.stall_in = s; bus.resume = r;
  endtask

  task automatic step(input bit h, v, s, r, input string name);
    @(negedge clk);
    drive(h, v, s, r);
    #2;
    chk(name, obs(), model_exp(h, v, s, r));
    model_upd(h, v, s, r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0);
    rst = 1'b1;
    #2;
    chk("reset_state", obs(), {3'b110, 2'b00, 8'd0});
    @(negedge clk);
    rst = 1'b0;
    m_drain = 0; m_halted = 1'b0; m_cnt = 0;
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0);
    #1 rst = 1'b1;

    // basic halt, resume in drain ignored, back-to-back, bubble, stall overlap
    tbl.push_back('{1,1,0,0, {3'b001,2'b00,8'd0}});
    tbl.push_back('{0,0,0,0, {3'b001,2'b10,8'd1}});
    tbl.push_back('{0,0,0,0, {3'b001,2'b10,8'd1}});
    tbl.push_back('{0,0,0,1, {3'b001,2'b10,8'd1}});
    tbl.push_back('{0,0,0,0, {3'b001,2'b01,8'd1}});
    tbl.push_back('{0,0,0,1, {3'b111,2'b01,8'd1}});
    tbl.push_back('{1,1,0,0, {3'b001,2'b00,8'd1}});
    tbl.push_back('{1,1,1,0, {3'b001,2'b10,8'd2}});
    tbl.push_back('{0,0,0,0, {3'b001,2'b10,8'd2}});
    tbl.push_back('{0,0,0,0, {3'b001,2'b10,8'd2}});
    tbl.push_back('{0,0,0,1, {3'b111,2'b01,8'd2}});
    tbl.push_back('{1,0,0,0, {3'b110,2'b00,8'd2}});
    tbl.push_back('{1,1,1,0, {3'b001,2'b00,8'd2}});
    tbl.push_back('{1,1,1,0, {3'b001,2'b00,8'd2}});
    tbl.push_back('{1,1,0,0, {3'b001,2'b00,8'd2}});
    tbl.push_back('{0,0,0,0, {3'b001,2'b10,8'd3}});
    tbl.push_back('{0,0,0,0, {3'b001,2'b10,8'd3}});
    tbl.push_back('{0,0,0,0, {3'b001,2'b10,8'd3}});
    tbl.push_back('{0,0,0,0, {3'b001,2'b01,8'd3}});
    tbl.push_back('{0,0,0,1, {3'b111,2'b01,8'd3}});
    tbl.push_back('{0,0,0,0, {3'b110,2'b00,8'd3}});

    do_reset();
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].h, tbl[i].v, tbl[i].s, tbl[i].r);
      #2;
      chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
    end

    // async reset in the middle of a drain, away from any clock edge
    do_reset();
    step(1, 1, 0, 0, "ar_take");
    step(0, 0, 0, 0, "ar_drain");
    @(negedge clk);
    drive(1, 1, 0, 0);
    #2 rst = 1'b1;
    #1 chk("ar_during_rst", obs(), {3'b110, 2'b00, 8'd0});
    bus.stall_in = 1'b1;
    #1 chk("ar_rst_stall", obs(), {3'b001, 2'b00, 8'd0});
    @(negedge clk);
    #3 rst = 1'b0;
    m_drain = 0; m_halted = 1'b0; m_cnt = 0;
    step(0, 0, 0, 0, "ar_after");

    // saturation over 256 halt/resume rounds
    do_reset();
    for (int i = 0; i < 256; i++) begin
      step(1, 1, 0, 0, "sat_take");
      for (int d = 0; d < DC; d++) step(0, 0, 0, 0, "sat_drain");
      step(0, 0, 0, 1, "sat_resume");
      if (i >= 254) chk("sat_hold", {5'b0, bus.halt_count}, 13'd255);
    end

    // randomized traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      step(($urandom % 3) == 0, ($urandom % 4) != 0, ($urandom % 4) == 0,
           ($urandom % 3) == 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
